// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the processor performance monitor.
// Event index constants name the ev[] bit of each tracked pipeline event.
package perf_pkg;

  localparam int unsigned PERF_NUM_EVENTS = 6;

  localparam int unsigned EV_RETIRE = 0;
  localparam int unsigned EV_IC_REQ = 1;
  localparam int unsigned EV_IC_HIT = 2;
  localparam int unsigned EV_DC_REQ = 3;
  localparam int unsigned EV_DC_HIT = 4;
  localparam int unsigned EV_STALL  = 5;

  typedef enum logic [1:0] {
    PERF_IDLE   = 2'd0,
    PERF_RUN    = 2'd1,
    PERF_FROZEN = 2'd2
  } perf_state_t;

endpackage

// File: rtl/perf_monitor_if.sv
// Counter read port of the performance monitor: request (en/sel) and
// registered response (valid/data/err).
interface perf_monitor_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SEL_W = 3
);

  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_err;

  modport master (
    output rd_en,
    output rd_sel,
    input  rd_valid,
    input  rd_data,
    input  rd_err
  );

  modport slave (
    input  rd_en,
    input  rd_sel,
    output rd_valid,
    output rd_data,
    output rd_err
  );

endinterface

// File: rtl/perf_monitor_counter.sv
// One performance counter with sticky overflow flag.
// Build option PERF_SAT_EN: saturate at all-ones instead of wrapping to zero.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic atMax;

  assign atMax = &cnt;

  // clr wins over inc; an increment at all-ones latches ovf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (atMax) begin
        ovf <= 1'b1;
`ifdef PERF_SAT_EN
        cnt <= cnt;
`else
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor: run/freeze FSM, NUM_EVENTS event counters plus a cycle
// counter, and a registered read port. Build option PERF_SAT_EN selects saturating counters.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  halt,
  input  logic [NUM_EVENTS-1:0] ev,
  perf_monitor_if.slave         rdPort,
  output logic [NUM_EVENTS:0]   ovf,
  output logic                  frozen
);

  localparam int unsigned NUM_CNT = NUM_EVENTS + 1;

  perf_state_t      state;
  perf_state_t      stateNext;
  logic [NUM_CNT-1:0] incVec;
  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [CNT_W-1:0] rdMux;
  logic             rdErrNext;

  // State register; frozen is registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= PERF_IDLE;
      frozen <= 1'b0;
    end else begin
      state  <= stateNext;
      frozen <= (stateNext == PERF_FROZEN);
    end
  end

  // Next state: clear has priority; halt only matters in RUN
  always_comb begin
    stateNext = state;
    if (clear) begin
      stateNext = PERF_IDLE;
    end else begin
      case (state)
        PERF_IDLE:   if (start) stateNext = PERF_RUN;
        PERF_RUN:    if (halt)  stateNext = PERF_FROZEN;
        PERF_FROZEN: stateNext = PERF_FROZEN;
        default:     stateNext = PERF_IDLE;
      endcase
    end
  end

  // Top counter is the cycle counter; the halt cycle itself is still counted
  always_comb begin
    incVec = '0;
    if (state == PERF_RUN) begin
      incVec = {1'b1, ev};
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gCnt
    perf_counter #(
      .CNT_W(CNT_W)
    ) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (incVec[g]),
      .clr (clear),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end

  // Read mux sees pre-increment values of the request cycle
  always_comb begin
    rdMux     = '0;
    rdErrNext = (rdPort.rd_sel > SEL_W'(NUM_EVENTS));
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rdPort.rd_sel == SEL_W'(i)) begin
        rdMux = cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPort.rd_valid <= 1'b0;
      rdPort.rd_data  <= '0;
      rdPort.rd_err   <= 1'b0;
    end else begin
      rdPort.rd_valid <= rdPort.rd_en;
      rdPort.rd_data  <= rdPort.rd_en ? rdMux : '0;
      rdPort.rd_err   <= rdPort.rd_en & rdErrNext;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit instance and a 4-bit instance
// sharing control/event inputs, each with its own read port.
module tb_perf_monitor;
  import perf_pkg::*;

  localparam int unsigned NE = 6;
  localparam int unsigned SW = 3;
`ifdef PERF_SAT_EN
  localparam int unsigned OVF_EXP = 15;
`else
  localparam int unsigned OVF_EXP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          halt = 1'b0;
  logic [NE-1:0] ev = '0;
  logic [NE:0]   ovf;
  logic [NE:0]   ovfS;
  logic          frozen;
  logic          frozenS;

  int checks = 0;
  int errors = 0;

  perf_monitor_if #(.CNT_W(32), .SEL_W(SW)) rdBus ();
  perf_monitor_if #(.CNT_W(4),  .SEL_W(SW)) rdBusS ();

  perf_monitor #(.NUM_EVENTS(NE), .CNT_W(32), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt(halt),
    .ev(ev), .rdPort(rdBus), .ovf(ovf), .frozen(frozen)
  );

  perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .SEL_W(SW)) dutS (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt(halt),
    .ev(ev), .rdPort(rdBusS), .ovf(ovfS), .frozen(frozenS)
  );

  always #5 clk = ~clk;

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rdMain(logic [SW-1:0] sel, logic [63:0] exp, logic expErr, string tag);
    rdBus.rd_en  = 1'b1;
    rdBus.rd_sel = sel;
    step();
    rdBus.rd_en  = 1'b0;
    chk({tag, "_valid"}, 64'(rdBus.rd_valid), 64'(1));
    chk({tag, "_data"},  64'(rdBus.rd_data),  exp);
    chk({tag, "_err"},   64'(rdBus.rd_err),   64'(expErr));
  endtask

  task automatic rdSmall(logic [SW-1:0] sel, logic [63:0] exp, string tag);
    rdBusS.rd_en  = 1'b1;
    rdBusS.rd_sel = sel;
    step();
    rdBusS.rd_en  = 1'b0;
    chk({tag, "_valid"}, 64'(rdBusS.rd_valid), 64'(1));
    chk({tag, "_data"},  64'(rdBusS.rd_data),  exp);
  endtask

  initial begin
    rdBus.rd_en   = 1'b0;
    rdBus.rd_sel  = '0;
    rdBusS.rd_en  = 1'b0;
    rdBusS.rd_sel = '0;

    // Reset state
    step(2);
    chk("rst_valid",  64'(rdBus.rd_valid), 64'(0));
    chk("rst_data",   64'(rdBus.rd_data),  64'(0));
    chk("rst_err",    64'(rdBus.rd_err),   64'(0));
    chk("rst_ovf",    64'(ovf),            64'(0));
    chk("rst_frozen", 64'(frozen),         64'(0));
    rst = 1'b1;
    step();

    // Ten cycles of retire+icache-req, then halt (halt cycle counted)
    start = 1'b1;
    step();
    start = 1'b0;
    ev = '0;
    ev[EV_RETIRE] = 1'b1;
    ev[EV_IC_REQ] = 1'b1;
    step(10);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t1_frozen", 64'(frozen), 64'(1));
    ev = '1;
    step(3);
    start = 1'b1;
    step();
    start = 1'b0;
    ev = '0;
    chk("t1_start_ignored", 64'(frozen), 64'(1));
    rdMain(3'(EV_RETIRE), 64'(11), 1'b0, "t1_ch0");
    rdMain(3'(EV_IC_REQ), 64'(11), 1'b0, "t1_ch1");
    rdMain(3'(EV_IC_HIT), 64'(0),  1'b0, "t1_ch2");
    rdMain(3'(NE),        64'(11), 1'b0, "t1_cyc");
    chk("t1_ovf", 64'(ovf), 64'(0));

    // Clear from FROZEN, then clear colliding with all-ones events in RUN
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t2_unfrozen", 64'(frozen), 64'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    ev = '1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    ev = '0;
    rdMain(3'(EV_RETIRE), 64'(0), 1'b0, "t2_ch0");
    ev = '1;
    step(2);
    ev = '0;
    rdMain(3'(NE), 64'(0), 1'b0, "t2_cyc_idle");
    start = 1'b1;
    step();
    start = 1'b0;
    ev[EV_IC_HIT] = 1'b1;
    step(3);
    ev = '0;
    rdMain(3'(EV_IC_HIT), 64'(3), 1'b0, "t2_ch2_resume");
    rdMain(3'(EV_RETIRE), 64'(0), 1'b0, "t2_ch0_resume");
    halt = 1'b1;
    step();
    halt = 1'b0;

    // 17 events on channel 2 overflow the 4-bit instance
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    ev[EV_IC_HIT] = 1'b1;
    step(17);
    ev = '0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    rdSmall(3'(EV_IC_HIT), 64'(OVF_EXP), "t3_small_ch2");
    chk("t3_small_ovf", 64'(ovfS), 64'(7'b1000100));
    rdMain(3'(EV_IC_HIT), 64'(17), 1'b0, "t3_main_ch2");
    chk("t3_main_ovf", 64'(ovf), 64'(0));

    // Out-of-range select, then back-to-back reads
    rdMain(3'(NE + 1), 64'(0), 1'b1, "t4_oor");
    rdBus.rd_en  = 1'b1;
    rdBus.rd_sel = 3'(EV_RETIRE);
    step();
    chk("t4_b0_valid", 64'(rdBus.rd_valid), 64'(1));
    chk("t4_b0_data",  64'(rdBus.rd_data),  64'(0));
    rdBus.rd_sel = 3'(EV_IC_REQ);
    step();
    chk("t4_b1_valid", 64'(rdBus.rd_valid), 64'(1));
    chk("t4_b1_data",  64'(rdBus.rd_data),  64'(0));
    rdBus.rd_sel = 3'(EV_IC_HIT);
    step();
    chk("t4_b2_valid", 64'(rdBus.rd_valid), 64'(1));
    chk("t4_b2_data",  64'(rdBus.rd_data),  64'(17));
    rdBus.rd_en = 1'b0;
    step();
    chk("t4_pulse_end", 64'(rdBus.rd_valid), 64'(0));

    // Reset asserted mid-RUN with a read in flight
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    ev = '1;
    step(20);
    chk("t5_small_ovf_set", 64'(ovfS), 64'(7'h7F));
    rdBus.rd_en  = 1'b1;
    rdBus.rd_sel = 3'(EV_RETIRE);
    step();
    rdBus.rd_en = 1'b0;
    chk("t5_pre_valid", 64'(rdBus.rd_valid), 64'(1));
    rst = 1'b0;
    #1;
    chk("t5_rst_valid",  64'(rdBus.rd_valid), 64'(0));
    chk("t5_rst_data",   64'(rdBus.rd_data),  64'(0));
    chk("t5_rst_ovfS",   64'(ovfS),           64'(0));
    chk("t5_rst_frozen", 64'(frozen),         64'(0));
    step();
    rst = 1'b1;
    step(3);
    rdMain(3'(EV_RETIRE), 64'(0), 1'b0, "t5_idle_ch0");
    rdMain(3'(NE),        64'(0), 1'b0, "t5_idle_cyc");

    // start and halt together in IDLE: RUN only
    ev = '0;
    ev[EV_STALL] = 1'b1;
    start = 1'b1;
    halt  = 1'b1;
    step();
    start = 1'b0;
    halt  = 1'b0;
    chk("t6_not_frozen", 64'(frozen), 64'(0));
    step(2);
    chk("t6_still_run", 64'(frozen), 64'(0));
    halt = 1'b1;
    step();
    halt = 1'b0;
    ev = '0;
    chk("t6_frozen", 64'(frozen), 64'(1));
    rdMain(3'(NE),       64'(3), 1'b0, "t6_cyc");
    rdMain(3'(EV_STALL), 64'(3), 1'b0, "t6_stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable, parametrised performance-monitor unit for the pipelined processor. It turns the per-cycle event strobes that the simulation bench counts today into hardware counters inside `proc`. Tracked events are retired instructions, I/D-cache requests and hits, and stalls, plus a cycle counter. Counting starts on a start pulse and freezes when Halt is seen in the memory stage. A registered read port returns one counter per request, with sticky overflow flags per channel.

## Interface
Parameters:
- `NUM_EVENTS`, default 6: number of event channels (index 0..NUM_EVENTS-1).
- `CNT_W`, default 32: width of every counter, including the cycle counter.
- `SEL_W`, default `$clog2(NUM_EVENTS+1)`: width of the read selector.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset. All state clears immediately on assertion.
- `start`  in  1: pulse; IDLE→RUN.
- `clear`  in  1: pulse; zeroes all counters and flags, then →IDLE.
- `halt`  in  1: Halt in memory stage; RUN→FROZEN.
- `ev`  in  NUM_EVENTS: per-cycle event strobes; one increment per cycle per set bit.
- `rd_en`  in  1: read request.
- `rd_sel`  in  SEL_W: counter index; the value NUM_EVENTS selects the cycle counter.
- `rd_valid`  out  1: read data valid; asserted the cycle after `rd_en`.
- `rd_data`  out  CNT_W: selected counter value.
- `rd_err`  out  1: `rd_sel` > NUM_EVENTS; valid with `rd_valid`.
- `ovf`  out  NUM_EVENTS+1: sticky overflow flags, one per counter; the MSB is the cycle counter.
- `frozen`  out  1: high in FROZEN.

## Operation
- FSM states are IDLE, RUN, FROZEN. Reset state is IDLE.
- IDLE:
  - `start`→RUN.
  - Counters hold.
- RUN:
  - Cycle counter +1 every cycle.
  - Event counter i +1 when `ev[i]`.
  - `halt`→FROZEN.
- FROZEN:
  - All counters hold.
  - `frozen`=1.
  - `start` is ignored; only `clear` leaves.
- `clear` is accepted in any state and has priority over every other input. Next cycle: all counters 0, `ovf` 0, state IDLE.
- The halt cycle is counted: in RUN, `ev` and the cycle increment in the same cycle as `halt` are applied, then the FSM freezes. This matches the bench, which counts the Halt instruction as retired.
- `start` and `halt` in the same cycle in IDLE: →RUN only. `halt` is evaluated only in RUN.
- Counter overflow: on an increment at all-ones, set the sticky `ovf[i]`. The value then follows the configured wrap or saturate rule (see Configuration).
- Reads:
  - Permitted in every state.
  - The value returned is the one registered at the end of the `rd_en` cycle, excluding any increment made in that same cycle.
  - Out-of-range `rd_sel`: `rd_data`=0 and `rd_err`=1.
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-count: immediate clear; no partial values are kept.

## Timing
- Increment latency: an event in cycle n is visible to a read issued in cycle n+1, with data out in n+2.
- Read latency: 1 cycle. `rd_valid` is a single-cycle pulse per `rd_en`. Back-to-back reads give one result per cycle.
- `clear` and `start` take effect on the next edge. `frozen` rises on the edge after `halt` is sampled in RUN.
- No combinational path from inputs to outputs.

## Configuration
- `PERF_SAT_EN`:
  - Defined: counters saturate at all-ones (2^CNT_W−1) and stay there until `clear`.
  - Undefined: counters wrap to 0.
  - `ovf` behaviour is identical in both cases.

## Structure
- Package `perf_pkg`:
  - FSM state enum `perf_state_t` (PERF_IDLE, PERF_RUN, PERF_FROZEN).
  - Event index constants EV_RETIRE=0, EV_IC_REQ=1, EV_IC_HIT=2, EV_DC_REQ=3, EV_DC_HIT=4, EV_STALL=5.
  - Default `NUM_EVENTS`.
- Sub-module `perf_counter`:
  - Ports: one CNT_W counter with `inc`, `clr`, `ovf`; saturate/wrap under `PERF_SAT_EN`.
  - Instantiated NUM_EVENTS+1 times via generate.
- Top level holds the FSM, the read mux and the read output registers.

## Test plan
- Reset, then `start`, 10 cycles of `ev`=6'b000011, then `halt` → counters 0 and 1 read 11, cycle counter reads 11, `frozen`=1; further `ev` changes nothing.
- `clear` asserted in the same cycle as `ev`=all-ones in RUN → next-cycle reads all 0, state IDLE; a following `start` resumes counting from 0.
- CNT_W=4, 17 events on channel 2:
  - with `PERF_SAT_EN` → reads 15, `ovf[2]`=1;
  - without → reads 1, `ovf[2]`=1.
- `rd_sel`=NUM_EVENTS+1 → `rd_data`=0, `rd_err`=1; back-to-back reads of sel 0,1,2 → three consecutive valid results, each one cycle after its `rd_en`.
- Assert `rst` low mid-RUN → all outputs 0 immediately; after release, state IDLE and `ev` is ignored until `start`.
- `start` and `halt` together in IDLE → RUN, not frozen; a subsequent `halt` freezes.
